// File: rtl/digit_scan_driver.sv
// digit_scan_driver
//   Time-multiplexed drive for a 4-digit common-anode seven-segment display.
//   Owns a 2-bit digit phase (0->1->2->3->0), advanced every PRESCALE clocks,
//   and double-buffers a 16-bit hex value so a new value only takes effect at
//   a frame boundary (no tearing mid-frame).
// Ports
//   clk          system clock, rising edge
//   state_reset  synchronous reset, active-high
//   enable       1 = scan, 0 = dark with scan counters held at 0
//   load         1-cycle strobe capturing value/dp_in into the shadow buffer
//   value        four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        decimal point per digit, 1 = lit
//   digit_sel    current scan phase
//   anode        active-low one-hot digit enable
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   frame_done   1-cycle pulse after the phase wraps 3->0
//   pending      shadow holds a value not yet shown
module digit_scan_driver #(
  parameter int unsigned PRESCALE      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        state_reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [1:0]  digit_sel,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    PH_D0 = 2'd0,
    PH_D1 = 2'd1,
    PH_D2 = 2'd2,
    PH_D3 = 2'd3
  } phase_e;

  phase_e      r_phase;
  phase_e      w_phase_nxt;
  logic [PW-1:0] r_presc;
  logic [15:0] r_shadow;
  logic [15:0] r_active;
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_active_dp;
  logic        r_pending;
  logic [3:0]  r_anode;
  logic [6:0]  r_seg;
  logic        r_dp;
  logic        r_frame_done;

  logic        w_tick;
  logic        w_boundary;
  logic [1:0]  w_sel;
  logic [3:0]  w_nib;
  logic [3:0]  w_lead_zero;
  logic        w_blank;

  // Active-low gfedcba hex decode
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tick     = enable && (r_presc == PW'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_phase == PH_D3);
  assign w_sel      = 2'(r_phase);
  assign w_nib      = r_active[{w_sel, 2'b00} +: 4];

  // Digit i (i>=1) is a leading zero when nibbles i..3 are all zero
  always_comb begin
    w_lead_zero    = 4'b0000;
    w_lead_zero[3] = (r_active[15:12] == 4'h0);
    w_lead_zero[2] = w_lead_zero[3] && (r_active[11:8] == 4'h0);
    w_lead_zero[1] = w_lead_zero[2] && (r_active[7:4] == 4'h0);
    w_blank        = BLANK_LEADING && w_lead_zero[w_sel];
  end

  // Phase state register
  always_ff @(posedge clk) begin
    if (state_reset) r_phase <= PH_D0;
    else             r_phase <= w_phase_nxt;
  end

  // Phase next-state: advance on tick, held at digit 0 while disabled
  always_comb begin
    w_phase_nxt = r_phase;
    if (!enable) begin
      w_phase_nxt = PH_D0;
    end else if (w_tick) begin
      case (r_phase)
        PH_D0:   w_phase_nxt = PH_D1;
        PH_D1:   w_phase_nxt = PH_D2;
        PH_D2:   w_phase_nxt = PH_D3;
        default: w_phase_nxt = PH_D0;
      endcase
    end
  end

  // Prescaler, double buffer and registered display decode
  always_ff @(posedge clk) begin
    if (state_reset) begin
      r_presc      <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_shadow_dp  <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
      r_anode      <= 4'b1111;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // A load landing on the boundary bypasses the shadow straight to active
      if (w_boundary && load) begin
        r_shadow    <= value;
        r_shadow_dp <= dp_in;
        r_active    <= value;
        r_active_dp <= dp_in;
        r_pending   <= 1'b0;
      end else if (load) begin
        r_shadow    <= value;
        r_shadow_dp <= dp_in;
        r_pending   <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
        r_pending   <= 1'b0;
      end

      if (!enable) begin
        r_presc      <= '0;
        r_anode      <= 4'b1111;
        r_seg        <= 7'h7F;
        r_dp         <= 1'b1;
        r_frame_done <= 1'b0;
      end else begin
        r_presc      <= w_tick ? '0 : r_presc + PW'(1);
        r_anode      <= ~(4'b0001 << w_sel);
        r_seg        <= w_blank ? 7'h7F : hex7(w_nib);
        r_dp         <= ~r_active_dp[w_sel];
        r_frame_done <= w_boundary;
      end
    end
  end

  assign digit_sel  = w_sel;
  assign anode      = r_anode;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule
